// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold, shift, rotate, load, asr, invert.
// Single-step via en, or multi-cycle bursts of a latched mode via start/cnt.
module shift_reg_univ #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  parameter logic [WIDTH-1:0]   SET_VAL = '1,
  parameter int                 CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sl_in,
  input  logic             sr_in,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             so_l,
  output logic             so_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [2:0]       lmode;
  logic [CNT_W-1:0] rem;

  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] r;
    r = v;
    unique case (m)
      3'b000: r = v;
      3'b001: r = {v[WIDTH-2:0], sl};
      3'b010: r = {sr, v[WIDTH-1:1]};
      3'b011: r = {v[WIDTH-2:0], v[WIDTH-1]};
      3'b100: r = {v[0], v[WIDTH-1:1]};
      3'b101: r = ld;
      3'b110: r = {v[WIDTH-1], v[WIDTH-1:1]};
      3'b111: r = ~v;
    endcase
    return r;
  endfunction

  assign so_l = q[WIDTH-1];
  assign so_r = q[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      q     <= RST_VAL;
      busy  <= 1'b0;
      done  <= 1'b0;
      state <= IDLE;
      rem   <= '0;
      lmode <= 3'b000;
    end else if (set) begin
      q     <= SET_VAL;
      busy  <= 1'b0;
      done  <= 1'b0;
      state <= IDLE;
      rem   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        RUN: begin
          q   <= step_op(lmode, q, sl_in, sr_in, d);
          rem <= rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            lmode <= mode;
            if (cnt == '0) begin
              done <= 1'b1;
            end else begin
              // first step of the burst happens on the accept edge
              q   <= step_op(mode, q, sl_in, sr_in, d);
              rem <= cnt - 1'b1;
              if (cnt == CNT_W'(1)) begin
                done <= 1'b1;
              end else begin
                state <= RUN;
                busy  <= 1'b1;
              end
            end
          end else if (en) begin
            q <= step_op(mode, q, sl_in, sr_in, d);
          end
        end
      endcase
    end
  end

endmodule
